ex_dispatch_arbiter: RTL and testbench



---
 rtl/ex_dispatch_arbiter_pkg.sv | 22 ++
 rtl/ex_rr_arbiter.sv | 52 +++++
 rtl/ex_dispatch_arbiter.sv | 154 +++++++++++++++
 tb/tb_ex_dispatch_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ex_dispatch_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_dispatch_arbiter_pkg
//  Description : Shared helpers for the execution-unit dispatch arbiter.
//                idx_w() returns the slot-index width. It is clog2 of the
//                slot count, but never less than 1 bit, so that a
//                single-slot build still has a legal index port.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package ex_dispatch_arbiter_pkg;

    // Slot-index width. A single-slot build still gets one index bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Depth of the output buffer in front of the execution unit.
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

endpackage : ex_dispatch_arbiter_pkg
`default_nettype wire

// File: rtl/ex_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ex_rr_arbiter
//  Description : Combinational round-robin priority picker. The scan starts
//                at slot ptr_i and wraps modulo NUM_REQS. The first valid
//                slot found wins.
//  Ports       : valids_i       - per-slot request valid
//                ptr_i          - slot with highest priority this cycle
//                grant_valid_o  - some slot was granted
//                grant_idx_o    - index of the granted slot
//                grant_onehot_o - one-hot form of grant_idx_o
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_rr_arbiter
    import ex_dispatch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS = 4,
    localparam int unsigned IDX_W   = idx_w(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] valids_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic                grant_valid_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic [NUM_REQS-1:0] grant_onehot_o
);

    // One extra bit so that ptr + offset cannot overflow before the wrap.
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        grant_valid_o  = 1'b0;
        grant_idx_o    = '0;
        grant_onehot_o = '0;
        w_sum          = '0;
        w_pos          = '0;
        for (int k = 0; k < int'(NUM_REQS); k++) begin
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQS)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQS);
            end
            w_pos = w_sum[IDX_W-1:0];
            if (!grant_valid_o && valids_i[w_pos]) begin
                grant_valid_o         = 1'b1;
                grant_idx_o           = w_pos;
                grant_onehot_o[w_pos] = 1'b1;
            end
        end
    end

endmodule : ex_rr_arbiter
`default_nettype wire

// File: rtl/ex_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ex_dispatch_arbiter
//  Description : Shares one execution-unit dispatch port among NUM_REQS issue
//                slots. A round-robin pick accepts one request per cycle into
//                a 2-entry output buffer. A counter tracks the cycles in
//                which a request is pending but none is accepted.
//  Ports       : clk, reset    - clock, async active-high reset
//                req_valid_i   - per-slot request valid
//                req_data_i    - per-slot payload
//                req_ready_o   - per-slot accept (at most one bit set)
//                out_valid_o   - buffered request available
//                out_data_o    - head payload
//                out_idx_o     - slot that produced the head payload
//                out_ready_i   - execution unit accepts head
//                perf_stalls_o - stall-cycle counter (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_dispatch_arbiter
    import ex_dispatch_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS      = 4,
    parameter int unsigned DATAW         = 128,
    parameter int unsigned PERF_CTR_BITS = 44,
    localparam int unsigned IDX_W        = idx_w(NUM_REQS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid_i,
    input  logic [NUM_REQS-1:0][DATAW-1:0] req_data_i,
    output logic [NUM_REQS-1:0]            req_ready_o,
    output logic                           out_valid_o,
    output logic [DATAW-1:0]               out_data_o,
    output logic [IDX_W-1:0]               out_idx_o,
    input  logic                           out_ready_i,
    output logic [PERF_CTR_BITS-1:0]       perf_stalls_o
);

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [IDX_W-1:0] idx;
    } dispatch_arb_entry_t;

    logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]               count_q,  count_d;
    dispatch_arb_entry_t      head_q,   head_d;
    dispatch_arb_entry_t      tail_q,   tail_d;
    logic [PERF_CTR_BITS-1:0] perf_q,   perf_d;

    logic                w_grant_valid;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [NUM_REQS-1:0] w_grant_onehot;
    logic                w_can_push;
    logic                w_push;
    logic                w_pop;
    logic                w_stall;
    dispatch_arb_entry_t w_new;

    ex_rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr_arbiter (
        .valids_i       (req_valid_i),
        .ptr_i          (rr_ptr_q),
        .grant_valid_o  (w_grant_valid),
        .grant_idx_o    (w_grant_idx),
        .grant_onehot_o (w_grant_onehot)
    );

    // Acceptance looks only at the buffer occupancy and never at out_ready_i.
    // While a full buffer is being popped, the push still waits one cycle.
    // This keeps the ready path free of the downstream handshake. Ready is
    // also held low while reset is asserted.
    assign w_can_push  = (count_q < FIFO_DEPTH) && !reset;
    assign w_push      = w_grant_valid && w_can_push;
    assign w_pop       = out_valid_o && out_ready_i;
    assign req_ready_o = w_grant_onehot & {NUM_REQS{w_can_push}};
    assign w_stall     = (|req_valid_i) && !(|(req_valid_i & req_ready_o));

    assign w_new.data = req_data_i[w_grant_idx];
    assign w_new.idx  = w_grant_idx;

    assign out_valid_o   = (count_q != 2'd0);
    assign out_data_o    = head_q.data;
    assign out_idx_o     = head_q.idx;
    assign perf_stalls_o = perf_q;

    // Round-robin pointer: move just past the winner, wrapping at NUM_REQS.
    // With a single slot this always evaluates to 0.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_push) begin
            if (w_grant_idx == IDX_W'(NUM_REQS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_grant_idx + IDX_W'(1);
            end
        end
    end

    // The buffer works as a two-register shift structure, so the head is
    // always read directly from head_q. A push goes to the head when the
    // head slot is free this cycle (the buffer is empty, or it holds one
    // entry that is being popped). Otherwise the push goes to the tail.
    // Pushes never happen at count 2, so the tail-to-head move on a pop
    // cannot collide with a push.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (w_push) begin
            if ((count_q == 2'd0) || w_pop) begin
                head_d = w_new;
            end else begin
                tail_d = w_new;
            end
        end
        if (w_pop && (count_q == FIFO_DEPTH)) begin
            head_d = tail_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        perf_d = perf_q;
        if (w_stall) begin
            perf_d = perf_q + PERF_CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            perf_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            perf_q   <= perf_d;
        end
    end

endmodule : ex_dispatch_arbiter
`default_nettype wire

// File: tb/tb_ex_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_dispatch_arbiter
//  Description : Self-checking bench for ex_dispatch_arbiter. It applies a
//                cycle-by-cycle vector table and then a hand-written
//                asynchronous-reset sequence.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_dispatch_arbiter;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 128;
    localparam int PCB      = 44;

    logic                           clk = 1'b0;
    logic                           reset;
    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0][DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]            req_ready;
    logic                           out_valid;
    logic [DATAW-1:0]               out_data;
    logic [1:0]                     out_idx;
    logic                           out_ready;
    logic [PCB-1:0]                 perf_stalls;

    int checks = 0;
    int errors = 0;

    ex_dispatch_arbiter #(
        .NUM_REQS      (NUM_REQS),
        .DATAW         (DATAW),
        .PERF_CTR_BITS (PCB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .out_valid_o   (out_valid),
        .out_data_o    (out_data),
        .out_idx_o     (out_idx),
        .out_ready_i   (out_ready),
        .perf_stalls_o (perf_stalls)
    );

    always #5 clk = ~clk;

    // Each slot carries a fixed payload, so the expected head data
    // follows directly from the expected slot index.
    function automatic logic [DATAW-1:0] slot_data(input int s);
        logic [31:0] w;
        w = 32'hD15A_0000 | 32'(s);
        return {4{w}};
    endfunction

    task automatic check(input string name, input logic [DATAW-1:0] act,
                         input logic [DATAW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]     rv;
        logic           ordy;
        logic [3:0]     rdy;
        logic           ov;
        logic [1:0]     idx;
        logic [PCB-1:0] perf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] rv, input logic ordy, input logic [3:0] rdy,
                       input logic ov, input logic [1:0] idx, input int perf);
        vec_t v;
        v.rv = rv; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.idx = idx;
        v.perf = PCB'(perf);
        vecs.push_back(v);
    endtask

    initial begin
        for (int s = 0; s < NUM_REQS; s++) req_data[s] = slot_data(s);
        reset     = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b0;

        //   rv       ordy  ready    ov    idx  perf   -- fairness from reset
        add(4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 0);
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 0);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 0);
        add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 0);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 0);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 0);
        // single requester on slot 2, then rr_ptr==3 favours slot 3
        add(4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 0);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 0);
        add(4'b0011, 1'b0, 4'b0001, 1'b0, 2'd0, 0);
        // push and pop together at count 1, new request on slot 3
        add(4'b1000, 1'b1, 4'b1000, 1'b1, 2'd0, 0);
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 0);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 0);
        // backpressure: two acceptances, then stalls accumulate
        add(4'b1111, 1'b0, 4'b0001, 1'b0, 2'd0, 0);
        add(4'b1111, 1'b0, 4'b0010, 1'b1, 2'd0, 0);
        add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 0);
        add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 1);
        add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 2);
        // full with pop: blocked this cycle, slot 0 accepted the next
        add(4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0, 3);
        add(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd1, 4);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 4);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 4);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 4);

        // reset state while reset is still asserted and all slots request
        #12;
        check("rst_req_ready", DATAW'(req_ready), '0);
        check("rst_out_valid", DATAW'(out_valid), '0);
        check("rst_out_idx",   DATAW'(out_idx), '0);
        check("rst_out_data",  out_data, '0);
        check("rst_perf",      DATAW'(perf_stalls), '0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            req_valid = vecs[i].rv;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_req_ready", i), DATAW'(req_ready), DATAW'(vecs[i].rdy));
            check($sformatf("v%0d_out_valid", i), DATAW'(out_valid), DATAW'(vecs[i].ov));
            check($sformatf("v%0d_perf", i), DATAW'(perf_stalls), DATAW'(vecs[i].perf));
            if (vecs[i].ov) begin
                check($sformatf("v%0d_out_idx", i), DATAW'(out_idx), DATAW'(vecs[i].idx));
                check($sformatf("v%0d_out_data", i), out_data, slot_data(int'(vecs[i].idx)));
            end
            @(negedge clk);
        end

        // Asynchronous reset with the buffer full (rr_ptr is 1 here).
        req_valid = 4'b1111;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("full_req_ready", DATAW'(req_ready), '0);
        check("full_out_idx",   DATAW'(out_idx), DATAW'(2'd1));
        check("full_out_data",  out_data, slot_data(1));
        @(posedge clk);
        #2;
        check("full_perf", DATAW'(perf_stalls), DATAW'(5));
        reset = 1'b1;
        #1;
        check("arst_out_valid", DATAW'(out_valid), '0);
        check("arst_req_ready", DATAW'(req_ready), '0);
        check("arst_perf",      DATAW'(perf_stalls), '0);
        check("arst_out_idx",   DATAW'(out_idx), '0);
        check("arst_out_data",  out_data, '0);
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_grant", DATAW'(req_ready), DATAW'(4'b0001));
        @(posedge clk);
        #1;
        check("post_rst_out_valid", DATAW'(out_valid), DATAW'(1'b1));
        check("post_rst_out_idx",   DATAW'(out_idx), '0);
        check("post_rst_out_data",  out_data, slot_data(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ex_dispatch_arbiter
`default_nettype wire
